// File: rtl/sync_filter_bank_pkg.sv
// Shared sizing helpers and parameter legality checks for the synchronizer filter bank.
package sync_filter_bank_pkg;

  localparam int unsigned DEPTH_MIN  = 2;
  localparam int unsigned DEPTH_MAX  = 8;
  localparam int unsigned FILTER_MAX = 255;

  // Stability counter width: enough bits to hold FILTER_CYCLES-1, never zero.
  function automatic int unsigned cnt_width(input int unsigned f);
    int unsigned w;
    w = 32'($clog2(f + 1));
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit depth_legal(input int unsigned d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
  endfunction

  function automatic bit filter_legal(input int unsigned f);
    return f <= FILTER_MAX;
  endfunction

endpackage

// File: rtl/sync_filter_bank_if.sv
// Level/pulse bundle between a filter bank and its core-side consumer.
interface sync_filter_bank_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  // Master drives the asynchronous levels and consumes the filtered view.
  modport master (output d, input q, rise, fall, changed);
  // Slave is the filter bank itself.
  modport slave  (input d, output q, rise, fall, changed);
endinterface

// File: rtl/sync_filter_chan.sv
// One channel: flop-chain synchronizer, optional stability filter, edge detector.
module sync_filter_chan
  import sync_filter_bank_pkg::*;
#(
  parameter int unsigned DEPTH         = 3,
  parameter logic        INIT          = 1'b0,
  parameter int unsigned FILTER_CYCLES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [DEPTH-1:0] sync_q;
  logic             raw;
  logic             hist_q;

  // Plain shift chain; nothing may sit between stages.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= {DEPTH{INIT}};
    else       sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign raw = sync_q[DEPTH-1];

  if (FILTER_CYCLES == 0) begin : g_bypass
    // Last sync stage is already a flop, so it drives the output directly.
    assign q_o = raw;
  end else begin : g_filter
    localparam int unsigned   CW       = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;

    // Count consecutive disagreeing cycles; any agreement clears the count.
    always_comb begin
      cnt_d = cnt_q;
      q_d   = q_q;
      if (raw == q_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        q_d   = raw;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Filter state; reset drops any pending count.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q <= '0;
        q_q   <= INIT;
      end else begin
        cnt_q <= cnt_d;
        q_q   <= q_d;
      end
    end

    assign q_o = q_q;
  end

  // Previous filtered level, used to find the first cycle of a new value.
  always_ff @(posedge clock) begin
    if (reset) hist_q <= INIT;
    else       hist_q <= q_o;
  end

  assign rise_o = q_o & ~hist_q;
  assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/sync_filter_bank.sv
// WIDTH independent synchronizer/filter/edge-detect channels with a combined change flag.
module sync_filter_bank
  import sync_filter_bank_pkg::*;
#(
  parameter int unsigned     WIDTH         = 1,
  parameter int unsigned     DEPTH         = 3,
  parameter logic [WIDTH-1:0] INIT         = '0,
  parameter int unsigned     FILTER_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_changed
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("sync_filter_bank: DEPTH must be in 2..8");
  end

  if (!filter_legal(FILTER_CYCLES)) begin : g_bad_filter
    $error("sync_filter_bank: FILTER_CYCLES must be in 0..255");
  end

  // One fully independent channel per input bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    sync_filter_chan #(
      .DEPTH         (DEPTH),
      .INIT          (INIT[i]),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .d_i    (io_d[i]),
      .q_o    (io_q[i]),
      .rise_o (io_rise[i]),
      .fall_o (io_fall[i])
    );
  end

  assign io_changed = |(io_rise | io_fall);

endmodule

// File: doc/sync_filter_bank.md
Name: sync_filter_bank

Overview:
Parametrised multi-channel successor to the single-bit output_chain synchronizer wrapper. It brings WIDTH independent asynchronous level inputs into the clock domain through a DEPTH-stage flop chain. Each channel then passes through an optional stability (debounce) filter and a per-channel edge detector. The block sits at the boundary of external or slow-domain status signals (interrupt lines, GPIO levels, debug handshake bits) and feeds core-side consumers.

Parameters:
WIDTH, 1, number of independent channels
DEPTH, 3, synchronizer stages per channel (legal 2..8)
INIT, 0, WIDTH-bit reset value of every stage, of the filtered output and of the edge history
FILTER_CYCLES, 0, consecutive cycles a new synchronized value must hold before io_q follows; 0 = filter bypassed (legal 0..255)

Ports:
clock  input  1  sole clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
io_d  input  WIDTH  asynchronous level inputs, one bit per channel
io_q  output  WIDTH  synchronized, filtered levels
io_rise  output  WIDTH  one-cycle pulse per channel on io_q 0->1
io_fall  output  WIDTH  one-cycle pulse per channel on io_q 1->0
io_changed  output  1  OR-reduction of (io_rise | io_fall)

Behaviour:
- Reset: synchronous and active-high. While reset is sampled high: all sync stages <= INIT, io_q <= INIT, filter counters <= 0, io_rise/io_fall <= 0. Reset asserted mid-filter discards the pending count, and no pulse is produced.
- Sync chain: per channel, s[0] <= io_d[i], s[k] <= s[k-1]. Raw level r[i] = s[DEPTH-1]. No logic between stages.
- Latency with FILTER_CYCLES=0: io_d stable before edge n gives io_q updated after edge n+DEPTH-1, i.e. visible in cycle n+DEPTH. io_q equals r directly, with no extra register.
- Filter, FILTER_CYCLES=F>0, counter cnt[i] of width max(1,clog2(F+1)):
  - r==io_q: cnt <= 0.
  - r!=io_q and cnt < F-1: cnt <= cnt+1.
  - r!=io_q and cnt == F-1: io_q <= r, cnt <= 0.
  - Net effect: io_q follows r after r has differed for exactly F consecutive cycles. Extra latency is F cycles.
  - A pulse on r shorter than F cycles never reaches io_q. Any reversion resets cnt, so there is no partial credit and cnt never exceeds F-1.
- Edge detect: registered copy h[i] of io_q, reset to INIT.
  - io_rise = io_q & ~h
  - io_fall = ~io_q & h
  - Each pulse is exactly one cycle and coincides with the first cycle of the new io_q value.
  - The first cycle after reset gives io_q == h == INIT, so no spurious pulse.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse, and io_changed is high once for that cycle.
- Input toggling every cycle with F>0 leaves io_q unchanged indefinitely (no starvation guarantee by design).
- No X propagation: io_d X is permitted only in simulation before the first reset.

Decomposition:
- Shared package: function cnt_width(F) returns max(1,$clog2(F+1)); parameter legality checks for DEPTH and FILTER_CYCLES, raised as elaboration errors.
- Sub-module: sync_filter_chan holds one channel (chain, counter, edge history) with scalar INIT. The top instantiates it WIDTH times in a generate loop and ORs the pulses into io_changed.

Test Plan:
- Reset/latency: WIDTH=1, DEPTH=3, F=0, INIT=0. Release reset, drive io_d 0->1 before edge 10 -> io_q=1 from cycle 13; io_rise high cycle 13 only; io_changed high cycle 13 only.
- INIT nonzero: WIDTH=4, INIT=4'b1010, io_d held at 4'b1010 through reset -> io_q=4'b1010 from first cycle after reset; no rise/fall pulses ever.
- Glitch rejection: DEPTH=2, F=4. A 3-cycle high pulse on io_d -> io_q stays 0, no pulses. A 4-cycle pulse -> io_q high for exactly 4 cycles, starting 2+4 cycles after the io_d rise, with one io_rise and one io_fall.
- Reversion resets count: F=4, io_d high 3 cycles, low 1, high 4 -> io_q rises only after the second run; cnt never observed above 3.
- Multi-channel simultaneity: WIDTH=8, F=2, io_d 8'h00->8'hA5 in one cycle -> io_rise=8'hA5 for one cycle, io_fall=0, io_changed single-cycle pulse.
- Mid-operation reset: F=5, io_d high 3 cycles then reset for 1 cycle -> io_q stays INIT; counting restarts from 0 after reset; rise appears DEPTH+5 cycles after the first post-reset sample of high.
